// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the unified memory port arbiter.
// Latency: none; this is just the wiring between requesters, arbiter and memory.
// Backpressure: requests are held by their owners until the matching grant is seen.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  // instruction-fetch side
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          if_err;
  // data side
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  // memory side
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rdata;

  // requesters plus the memory array
  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_a, mem_we, mem_wd
  );

  // the arbiter
  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and data access.
// Latency: grant in N, memory access in N+1, response pulse in N+2; one access per cycle.
// Backpressure: losing requester is simply not granted and keeps its request held.
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int MEM_WORDS    = 16001,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  // grants and starvation tracking
  logic       if_gnt_w, d_gnt_w, fetch_ok, fetch_pri;
  logic [2:0] starve_q, starve_d;

  // access stage
  logic          acc_vld_q, acc_vld_d;
  logic          acc_own_q, acc_own_d;   // 1 = data port, 0 = fetch port
  logic          acc_we_q,  acc_we_d;    // only set for clean data stores
  logic          acc_err_q, acc_err_d;
  logic [AW-1:0] acc_addr_q, acc_addr_d; // zero when idle or errored
  logic [DW-1:0] acc_wd_q,  acc_wd_d;    // zero unless a clean store
  logic [AW-1:0] sel_addr;
  logic          sel_err;

  // response stage
  logic          d_rvalid_q, d_rvalid_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          d_err_q, d_err_d, if_err_q, if_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d, if_rdata_q, if_rdata_d;

  // Misaligned or beyond the last implemented word.
  function automatic logic addr_err(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[AW-1:2]} >= AW'(MEM_WORDS));
  endfunction

  // Pick a winner: data by default, fetch once it has starved long enough; nothing under reset.
  always_comb begin
    if_gnt_w  = 1'b0;
    d_gnt_w   = 1'b0;
    fetch_ok  = bus.if_req & ~bus.if_flush;
    fetch_pri = (starve_q >= 3'(STARVE_LIMIT));
    if (rst) begin
      if (bus.d_req && !(fetch_ok && fetch_pri)) d_gnt_w = 1'b1;
      else if (fetch_ok)                          if_gnt_w = 1'b1;
    end
  end

  // Saturating count of cycles a live fetch request was passed over.
  always_comb begin
    starve_d = 3'd0;
    if (bus.if_req && !if_gnt_w && !bus.if_flush)
      starve_d = (starve_q == 3'd7) ? 3'd7 : starve_q + 3'd1;
  end

  // Build the access-stage contents from the winning request.
  always_comb begin
    sel_addr   = d_gnt_w ? bus.d_addr : bus.if_addr;
    sel_err    = addr_err(sel_addr);
    acc_vld_d  = d_gnt_w | if_gnt_w;
    acc_own_d  = d_gnt_w;
    acc_err_d  = acc_vld_d & sel_err;
    acc_we_d   = d_gnt_w & bus.d_we & ~sel_err;
    acc_addr_d = (acc_vld_d && !sel_err) ? sel_addr : '0;
    acc_wd_d   = acc_we_d ? bus.d_wdata : '0;
  end

  // Turn the access stage plus memory read data into next-cycle responses.
  // A flush kills the fetch currently in the access stage; its read is harmless.
  always_comb begin
    d_rvalid_d  = acc_vld_q & acc_own_q;
    if_rvalid_d = acc_vld_q & ~acc_own_q & ~bus.if_flush;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    if (d_rvalid_d) begin
      d_rdata_d = (acc_err_q || acc_we_q) ? '0 : bus.mem_rdata;
      d_err_d   = acc_err_q;
    end
    if (if_rvalid_d) begin
      if_rdata_d = acc_err_q ? '0 : bus.mem_rdata;
      if_err_d   = acc_err_q;
    end
  end

  // All pipeline state; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q    <= 3'd0;
      acc_vld_q   <= 1'b0;
      acc_own_q   <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_err_q   <= 1'b0;
      acc_addr_q  <= '0;
      acc_wd_q    <= '0;
      d_rvalid_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_err_q     <= 1'b0;
      if_err_q    <= 1'b0;
      d_rdata_q   <= '0;
      if_rdata_q  <= '0;
    end else begin
      starve_q    <= starve_d;
      acc_vld_q   <= acc_vld_d;
      acc_own_q   <= acc_own_d;
      acc_we_q    <= acc_we_d;
      acc_err_q   <= acc_err_d;
      acc_addr_q  <= acc_addr_d;
      acc_wd_q    <= acc_wd_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rvalid_q <= if_rvalid_d;
      d_err_q     <= d_err_d;
      if_err_q    <= if_err_d;
      d_rdata_q   <= d_rdata_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt_w;
  assign bus.d_gnt     = d_gnt_w;
  assign bus.mem_a     = acc_addr_q;
  assign bus.mem_we    = acc_we_q;
  assign bus.mem_wd    = acc_wd_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign busy          = acc_vld_q | d_rvalid_q | if_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   errs;
  int   checks;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Memory array owned by the bench: bulk init, backdoor writes and DUT stores.
  logic [31:0] mem [0:16383];
  logic        mem_init;
  logic        bd_we;
  logic [13:0] bd_idx;
  logic [31:0] bd_dat;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    end else begin
      if (bd_we)      mem[bd_idx] <= bd_dat;
      if (bus.mem_we) mem[bus.mem_a[15:2]] <= bus.mem_wd;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_a[15:2]];

  // Reference memory for the randomized run, updated in grant order.
  logic [31:0] ref_mem [0:16383];

  typedef struct {
    int          due;
    bit          is_if;
    bit          killed;
    logic [31:0] rdata;
    bit          err;
  } rec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic backdoor(input int idx, input logic [31:0] dat);
    bd_idx = 14'(idx); bd_dat = dat; bd_we = 1;
    tick();
    bd_we = 0;
  endtask

  // Single isolated access; returns what was seen at grant, access and response time.
  task automatic do_access(input bit is_if, input bit we, input logic [15:0] a, input logic [31:0] wd,
                           output bit gnt, output logic [15:0] ma, output bit mwe,
                           output bit rv, output bit er, output logic [31:0] rd);
    if (is_if) begin bus.if_req = 1; bus.if_addr = a; end
    else begin bus.d_req = 1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; end
    @(negedge clk);
    gnt = is_if ? bus.if_gnt : bus.d_gnt;
    tick();
    set_idle();
    ma = bus.mem_a; mwe = bus.mem_we;
    tick();
    rv = is_if ? bus.if_rvalid : bus.d_rvalid;
    er = is_if ? bus.if_err : bus.d_err;
    rd = is_if ? bus.if_rdata : bus.d_rdata;
  endtask

  task automatic test_reset();
    rst = 0; mem_init = 1; bd_we = 0; bd_idx = '0; bd_dat = '0;
    set_idle();
    bus.d_req = 1; bus.if_req = 1; bus.d_addr = 16'h0010; bus.if_addr = 16'h0020;
    repeat (2) @(posedge clk);
    #1 mem_init = 0;
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b0) begin errs++; $display("FAIL reset_d_gnt: got %b want 0", bus.d_gnt); end
    checks++; if (bus.if_gnt !== 1'b0) begin errs++; $display("FAIL reset_if_gnt: got %b want 0", bus.if_gnt); end
    checks++; if ({bus.mem_we, bus.mem_a, bus.mem_wd} !== 49'd0) begin errs++; $display("FAIL reset_mem: we=%b a=%h wd=%h want all 0", bus.mem_we, bus.mem_a, bus.mem_wd); end
    checks++; if ({bus.d_rvalid, bus.if_rvalid, bus.d_err, bus.if_err, busy} !== 5'd0) begin errs++; $display("FAIL reset_flags: got %b want 00000", {bus.d_rvalid, bus.if_rvalid, bus.d_err, bus.if_err, busy}); end
    checks++; if ({bus.d_rdata, bus.if_rdata} !== 64'd0) begin errs++; $display("FAIL reset_rdata: got %h %h want 0", bus.d_rdata, bus.if_rdata); end
    set_idle();
    rst = 1;
    tick();
  endtask

  task automatic test_single_load();
    backdoor(4, 32'hDEADBEEF);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0010;
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin errs++; $display("FAIL load_gnt: d=%b if=%b want 1 0", bus.d_gnt, bus.if_gnt); end
    tick();
    set_idle();
    checks++; if (bus.mem_a !== 16'h0010 || bus.mem_we !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL load_access: a=%h we=%b busy=%b want 0010 0 1", bus.mem_a, bus.mem_we, busy); end
    tick();
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0) begin errs++; $display("FAIL load_rvalid: rv=%b err=%b want 1 0", bus.d_rvalid, bus.d_err); end
    checks++; if (bus.d_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL load_rdata: got %h want deadbeef", bus.d_rdata); end
    tick();
    checks++; if (bus.d_rvalid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL load_idle: rv=%b busy=%b want 0 0", bus.d_rvalid, busy); end
  endtask

  task automatic test_store_load();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0020; bus.d_wdata = 32'h12345678;
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1) begin errs++; $display("FAIL st_gnt: got %b want 1", bus.d_gnt); end
    tick();
    bus.d_we = 0; bus.d_wdata = '0;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_a !== 16'h0020 || bus.mem_wd !== 32'h12345678) begin errs++; $display("FAIL st_access: we=%b a=%h wd=%h want 1 0020 12345678", bus.mem_we, bus.mem_a, bus.mem_wd); end
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1) begin errs++; $display("FAIL ld_after_st_gnt: got %b want 1", bus.d_gnt); end
    tick();
    set_idle();
    checks++; if (bus.mem_we !== 1'b0) begin errs++; $display("FAIL st_we_one_cycle: got %b want 0", bus.mem_we); end
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'h0) begin errs++; $display("FAIL st_resp: rv=%b err=%b rd=%h want 1 0 0", bus.d_rvalid, bus.d_err, bus.d_rdata); end
    tick();
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h12345678) begin errs++; $display("FAIL ld_after_st: rv=%b rd=%h want 1 12345678", bus.d_rvalid, bus.d_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0000;
    bus.if_req = 1; bus.if_addr = 16'h0100;
    for (int c = 0; c < 10; c++) begin
      bit exp_if;
      exp_if = (c == 4) || (c == 9);
      @(negedge clk);
      checks++; if (bus.if_gnt !== exp_if || bus.d_gnt !== !exp_if) begin errs++; $display("FAIL starve_c%0d: if=%b d=%b want %b %b", c, bus.if_gnt, bus.d_gnt, exp_if, !exp_if); end
      tick();
    end
    set_idle();
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL starve_drain: busy=%b want 0", busy); end
  endtask

  task automatic test_errors();
    bit g, mwe, rv, er;
    logic [15:0] ma;
    logic [31:0] rd;
    do_access(0, 1, 16'h0006, 32'hAAAA5555, g, ma, mwe, rv, er, rd);
    checks++; if (g !== 1'b1 || mwe !== 1'b0 || ma !== 16'h0) begin errs++; $display("FAIL err_mis_store: gnt=%b we=%b a=%h want 1 0 0000", g, mwe, ma); end
    checks++; if (rv !== 1'b1 || er !== 1'b1) begin errs++; $display("FAIL err_mis_store_resp: rv=%b err=%b want 1 1", rv, er); end
    do_access(1, 0, 16'hFB08, 32'h0, g, ma, mwe, rv, er, rd);
    checks++; if (g !== 1'b1 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin errs++; $display("FAIL err_if_range: gnt=%b rv=%b err=%b rd=%h want 1 1 1 0", g, rv, er, rd); end
    backdoor(16000, 32'h600DF00D);
    do_access(1, 0, 16'hFA00, 32'h0, g, ma, mwe, rv, er, rd);
    checks++; if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h600DF00D || ma !== 16'hFA00) begin errs++; $display("FAIL last_word: rv=%b err=%b rd=%h a=%h want 1 0 600df00d fa00", rv, er, rd, ma); end
    do_access(0, 0, 16'hFA04, 32'h0, g, ma, mwe, rv, er, rd);
    checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin errs++; $display("FAIL first_bad_word: rv=%b err=%b rd=%h want 1 1 0", rv, er, rd); end
    tick();
  endtask

  task automatic test_flush();
    backdoor(17, 32'hF00DCAFE);
    bus.if_req = 1; bus.if_addr = 16'h0040;
    @(negedge clk);
    checks++; if (bus.if_gnt !== 1'b1) begin errs++; $display("FAIL flush_first_gnt: got %b want 1", bus.if_gnt); end
    tick();
    bus.if_addr = 16'h0044; bus.if_flush = 1;
    @(negedge clk);
    checks++; if (bus.if_gnt !== 1'b0) begin errs++; $display("FAIL flush_blocks_gnt: got %b want 0", bus.if_gnt); end
    tick();
    bus.if_flush = 0;
    checks++; if (bus.if_rvalid !== 1'b0) begin errs++; $display("FAIL flush_kills_resp: got %b want 0", bus.if_rvalid); end
    @(negedge clk);
    checks++; if (bus.if_gnt !== 1'b1) begin errs++; $display("FAIL flush_regrant: got %b want 1", bus.if_gnt); end
    tick();
    set_idle();
    tick();
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hF00DCAFE) begin errs++; $display("FAIL flush_after_resp: rv=%b rd=%h want 1 f00dcafe", bus.if_rvalid, bus.if_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_store();
    backdoor(12, 32'h0BADC0DE);
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0030; bus.d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1) begin errs++; $display("FAIL rst_store_gnt: got %b want 1", bus.d_gnt); end
    tick();
    set_idle();
    checks++; if (bus.mem_we !== 1'b1) begin errs++; $display("FAIL rst_store_we: got %b want 1", bus.mem_we); end
    #2 rst = 0;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_a !== 16'h0 || bus.mem_wd !== 32'h0 || busy !== 1'b0) begin errs++; $display("FAIL rst_async: we=%b a=%h wd=%h busy=%b want all 0", bus.mem_we, bus.mem_a, bus.mem_wd, busy); end
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    checks++; if (mem[12] !== 32'h0BADC0DE) begin errs++; $display("FAIL rst_mem_kept: got %h want 0badc0de", mem[12]); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.d_rvalid !== 1'b0) begin errs++; $display("FAIL rst_no_resp_c%0d: got %b want 0", c, bus.d_rvalid); end
    end
  endtask

  function automatic logic [15:0] rand_addr();
    int k;
    k = $urandom_range(7);
    case (k)
      0:       rand_addr = {6'd0, 8'($urandom_range(63)), 2'($urandom_range(3, 1))};
      1:       rand_addr = {14'($urandom_range(16383, 16001)), 2'b00};
      2:       rand_addr = {14'd16000, 2'b00};
      default: rand_addr = {10'd0, 4'($urandom_range(15)), 2'b00};
    endcase
  endfunction

  task automatic test_random();
    rec_t q[$];
    rec_t r;
    int cyc, starve, idx;
    bit dp, ip, gd, gi, fok, found, edv, eiv, aerr;
    cyc = 0; starve = 0; dp = 0; ip = 0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = mem[i];
    for (int n = 0; n < 500; n++) begin
      if (!dp && $urandom_range(2) != 0) begin
        dp = 1; bus.d_we = 1'($urandom_range(1)); bus.d_addr = rand_addr(); bus.d_wdata = $urandom;
      end
      if (!ip && $urandom_range(2) != 0) begin
        ip = 1; bus.if_addr = rand_addr();
      end
      bus.d_req = dp; bus.if_req = ip;
      bus.if_flush = ($urandom_range(5) == 0);
      @(negedge clk);
      // arbitration rules
      fok = ip && !bus.if_flush;
      gi = fok && (!dp || starve >= 4);
      gd = dp && !gi;
      checks++; if (bus.d_gnt !== gd || bus.if_gnt !== gi) begin errs++; $display("FAIL rnd_gnt cyc%0d: d=%b if=%b want %b %b", cyc, bus.d_gnt, bus.if_gnt, gd, gi); end
      starve = (ip && !gi && !bus.if_flush) ? ((starve < 7) ? starve + 1 : 7) : 0;
      if (bus.if_flush)
        foreach (q[k]) if (q[k].is_if && q[k].due >= cyc + 1) q[k].killed = 1;
      if (gd || gi) begin
        logic [15:0] a;
        a = gd ? bus.d_addr : bus.if_addr;
        idx = int'(a >> 2);
        aerr = (a % 4 != 0) || (idx >= 16001);
        r.due = cyc + 2; r.is_if = gi; r.killed = 0; r.err = aerr;
        r.rdata = (aerr || (gd && bus.d_we)) ? 32'h0 : ref_mem[idx];
        if (gd && bus.d_we && !aerr) ref_mem[idx] = bus.d_wdata;
        q.push_back(r);
        if (gd) dp = 0; else ip = 0;
      end
      tick();
      cyc++;
      found = 0;
      foreach (q[k]) if (q[k].due == cyc) begin found = 1; r = q[k]; end
      edv = found && !r.is_if;
      eiv = found && r.is_if && !r.killed;
      checks++; if (bus.d_rvalid !== edv || bus.if_rvalid !== eiv) begin errs++; $display("FAIL rnd_rvalid cyc%0d: d=%b if=%b want %b %b", cyc, bus.d_rvalid, bus.if_rvalid, edv, eiv); end
      if (edv) begin
        checks++; if (bus.d_rdata !== r.rdata || bus.d_err !== r.err) begin errs++; $display("FAIL rnd_d_resp cyc%0d: rd=%h err=%b want %h %b", cyc, bus.d_rdata, bus.d_err, r.rdata, r.err); end
      end
      if (eiv) begin
        checks++; if (bus.if_rdata !== r.rdata || bus.if_err !== r.err) begin errs++; $display("FAIL rnd_if_resp cyc%0d: rd=%h err=%b want %h %b", cyc, bus.if_rdata, bus.if_err, r.rdata, r.err); end
      end
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    end
    set_idle();
    repeat (3) tick();
  endtask

  initial begin
    errs = 0;
    checks = 0;
    test_reset();
    test_single_load();
    test_store_load();
    test_starvation();
    test_errors();
    test_flush();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
